// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and default parameters for the period meter
// Purpose: FSM state encoding and default counter/timeout sizing.
// Ports: none (package).
package period_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pm_state_t;

    localparam int CNT_W_DEF   = 21;
    localparam int TIMEOUT_DEF = 2_000_000;

endpackage

// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - result/handshake bundle between period meter and its consumer
// Purpose: carries the captured period, valid/ack handshake, edge pulse and sticky flags.
// Ports (master = meter side):
//   period_o  : last captured period in clk_i cycles
//   valid_o   : period_o holds an unacknowledged result
//   ack_i     : consumer acknowledge, meaningful only while valid_o = 1
//   edge_o    : one-cycle pulse per detected rising edge
//   overrun_o : sticky, a result was overwritten before being acknowledged
//   timeout_o : sticky, no edge arrived within TIMEOUT cycles
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic [CNT_W-1:0] period_o;
    logic             valid_o;
    logic             ack_i;
    logic             edge_o;
    logic             overrun_o;
    logic             timeout_o;

    modport master (
        output period_o, valid_o, edge_o, overrun_o, timeout_o,
        input  ack_i
    );

    modport slave (
        input  period_o, valid_o, edge_o, overrun_o, timeout_o,
        output ack_i
    );
endinterface

// File: rtl/period_meter_sync_edge_detect.sv
// rtl/period_meter_sync_edge_detect.sv - two-flop synchronizer plus rising-edge detector
// Purpose: brings an asynchronous line into clk_i and pulses rise_o once per rising edge.
// Ports:
//   clk_i   : system clock
//   reset_n : asynchronous active-low reset
//   async_i : asynchronous input line
//   rise_o  : one-cycle pulse, s2 & ~s3
module sync_edge_detect (
    input  logic clk_i,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s1 may be metastable; only s2/s3 feed logic.
    assign rise_o = s2 & ~s3;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures the period of a slow asynchronous square wave in clk_i cycles
// Purpose: counts clk_i cycles between rising edges of sig_i and hands each result to a
//          consumer over a valid/ack handshake, with sticky overrun and timeout flags.
// Ports:
//   clk_i   : system clock
//   reset_n : asynchronous active-low reset
//   sig_i   : measured signal, asynchronous to clk_i
//   pm      : period_meter_if master (period_o, valid_o, ack_i, edge_o, overrun_o, timeout_o)
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk_i,
    input  logic           reset_n,
    input  logic           sig_i,
    period_meter_if.master pm
);

    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TIMEOUT - 1);

    pm_state_t        state;
    logic [CNT_W-1:0] count;
    logic             rise;
    logic             capture;

    sync_edge_detect u_sync (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .async_i (sig_i),
        .rise_o  (rise)
    );

    assign pm.edge_o = rise;

    // The first edge after IDLE only starts the count; later edges close a period.
    assign capture = rise && (state == RUN);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            pm.period_o  <= '0;
            pm.valid_o   <= 1'b0;
            pm.overrun_o <= 1'b0;
            pm.timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (rise) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // An edge on the timeout cycle still counts as an edge.
                    if (rise) begin
                        count <= '0;
                    end else if (count == COUNT_LAST) begin
                        count        <= '0;
                        pm.timeout_o <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase

            if (capture) begin
                pm.period_o  <= count + CNT_W'(1);
                pm.timeout_o <= 1'b0;
            end

            // A capture coinciding with ack keeps valid high with the fresh data.
            if (capture) begin
                pm.valid_o <= 1'b1;
            end else if (pm.valid_o && pm.ack_i) begin
                pm.valid_o <= 1'b0;
            end

            // Setting an overrun takes priority over an ack clearing it.
            if (capture && pm.valid_o && !pm.ack_i) begin
                pm.overrun_o <= 1'b1;
            end else if (pm.valid_o && pm.ack_i) begin
                pm.overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - self-checking bench for period_meter
module tb_period_meter;

    localparam int CNT_W   = 21;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sig_i = 1'b0;

    int total = 0;
    int bad = 0;

    int exp_q[$];
    logic prev_edge = 1'b0;

    period_meter_if #(.CNT_W(CNT_W)) pif ();

    period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i   (clk),
        .reset_n (reset_n),
        .sig_i   (sig_i),
        .pm      (pif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Scoreboard: a capture lands on the posedge that ends the edge_o cycle.
    always @(negedge clk) begin
        if (prev_edge && exp_q.size() > 0) begin
            int e;
            e = exp_q.pop_front();
            total++;
            if (pif.period_o !== CNT_W'(e)) begin
                bad++;
                $display("FAIL scoreboard_period: got %0d expected %0d", pif.period_o, e);
            end
        end
        prev_edge = pif.edge_o;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sig_i = 1'b0;
        pif.ack_i = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Rise, hold hi cycles, fall, hold lo cycles. exp != 0 queues the period this rise closes.
    task automatic pulse(input int exp, input int hi, input int lo);
        if (exp != 0) exp_q.push_back(exp);
        sig_i = 1'b1;
        repeat (hi) tick();
        sig_i = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sig_i = 1'b0;
        pif.ack_i = 1'b0;
        repeat (2) tick();
        total++; if (pif.period_o !== '0) begin bad++; $display("FAIL reset_period: got %0d expected 0", pif.period_o); end
        total++; if (pif.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", pif.valid_o); end
        total++; if (pif.edge_o !== 1'b0) begin bad++; $display("FAIL reset_edge: got %b expected 0", pif.edge_o); end
        total++; if (pif.overrun_o !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", pif.overrun_o); end
        total++; if (pif.timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b expected 0", pif.timeout_o); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_no_ack();
        apply_reset();
        pulse(0, 10, 10);
        pulse(20, 10, 10);
        total++; if (pif.valid_o !== 1'b1) begin bad++; $display("FAIL noack_valid1: got %b expected 1", pif.valid_o); end
        total++; if (pif.overrun_o !== 1'b0) begin bad++; $display("FAIL noack_overrun1: got %b expected 0", pif.overrun_o); end
        pulse(20, 10, 10);
        total++; if (pif.overrun_o !== 1'b1) begin bad++; $display("FAIL noack_overrun2: got %b expected 1", pif.overrun_o); end
        total++; if (pif.period_o !== CNT_W'(20)) begin bad++; $display("FAIL noack_period2: got %0d expected 20", pif.period_o); end
        pif.ack_i = 1'b1;
        tick();
        pif.ack_i = 1'b0;
        total++; if (pif.overrun_o !== 1'b0) begin bad++; $display("FAIL ack_clears_overrun: got %b expected 0", pif.overrun_o); end
        total++; if (pif.valid_o !== 1'b0) begin bad++; $display("FAIL ack_clears_valid: got %b expected 0", pif.valid_o); end
    endtask

    task automatic test_ack_pulsed();
        int acks;
        acks = 0;
        apply_reset();
        fork
            begin
                pulse(0, 10, 10);
                pulse(20, 10, 10);
                pulse(20, 10, 10);
                pulse(20, 10, 10);
            end
            begin
                for (int c = 0; c < 82; c++) begin
                    tick();
                    if (pif.ack_i) begin
                        pif.ack_i = 1'b0;
                        acks++;
                        total++;
                        if (pif.valid_o !== 1'b0) begin bad++; $display("FAIL ack_valid_drop: got %b expected 0", pif.valid_o); end
                    end else if (pif.valid_o) begin
                        pif.ack_i = 1'b1;
                    end
                end
            end
        join
        total++; if (acks !== 3) begin bad++; $display("FAIL ack_count: got %0d expected 3", acks); end
        total++; if (pif.overrun_o !== 1'b0) begin bad++; $display("FAIL ack_overrun: got %b expected 0", pif.overrun_o); end
    endtask

    task automatic test_ack_coincident();
        bit seen;
        seen = 1'b0;
        apply_reset();
        pulse(0, 10, 10);
        pulse(20, 7, 7);
        fork
            pulse(14, 7, 7);
            begin
                for (int c = 0; c < 6 && !seen; c++) begin
                    tick();
                    if (pif.edge_o && pif.valid_o) begin
                        seen = 1'b1;
                        pif.ack_i = 1'b1;
                        tick();
                        pif.ack_i = 1'b0;
                        total++; if (pif.valid_o !== 1'b1) begin bad++; $display("FAIL coinc_valid: got %b expected 1", pif.valid_o); end
                        total++; if (pif.period_o !== CNT_W'(14)) begin bad++; $display("FAIL coinc_period: got %0d expected 14", pif.period_o); end
                        total++; if (pif.overrun_o !== 1'b0) begin bad++; $display("FAIL coinc_overrun: got %b expected 0", pif.overrun_o); end
                    end
                end
            end
        join
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL coinc_edge_seen: got %b expected 1", seen); end
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        apply_reset();
        seen = 1'b0;
        sig_i = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (pif.edge_o) seen = 1'b1;
        end
        sig_i = 1'b0;
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL to_edge_seen: got %b expected 1", seen); end
        // Flag set on the posedge TIMEOUT cycles after the one ending edge_o; seen on the next negedge.
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (pif.timeout_o) seen = 1'b1;
        end
        total++; if (n !== TIMEOUT + 1) begin bad++; $display("FAIL to_latency: got %0d expected %0d", n, TIMEOUT + 1); end
        total++; if (pif.valid_o !== 1'b0) begin bad++; $display("FAIL to_valid: got %b expected 0", pif.valid_o); end
        pulse(0, 15, 15);
        total++; if (pif.valid_o !== 1'b0) begin bad++; $display("FAIL to_idle_nocapture: got %b expected 0", pif.valid_o); end
        total++; if (pif.timeout_o !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b expected 1", pif.timeout_o); end
        pulse(30, 15, 15);
        total++; if (pif.period_o !== CNT_W'(30)) begin bad++; $display("FAIL to_period30: got %0d expected 30", pif.period_o); end
        total++; if (pif.timeout_o !== 1'b0) begin bad++; $display("FAIL to_cleared: got %b expected 1'b0", pif.timeout_o); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        apply_reset();
        pulse(0, 5, 5);
        reset_n = 1'b0;
        sig_i = 1'b1;
        #1;
        total++; if (pif.edge_o !== 1'b0 || pif.valid_o !== 1'b0 || pif.period_o !== '0 || pif.overrun_o !== 1'b0 || pif.timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got edge=%b valid=%b period=%0d ovr=%b to=%b expected all 0", pif.edge_o, pif.valid_o, pif.period_o, pif.overrun_o, pif.timeout_o);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (pif.edge_o) seen = 1'b1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL midreset_synthetic_edge: got %b expected 1", seen); end
        sig_i = 1'b0;
        repeat (10) tick();
        total++; if (pif.valid_o !== 1'b0) begin bad++; $display("FAIL midreset_nocapture: got %b expected 0", pif.valid_o); end
        pulse(20, 5, 5);
        total++; if (pif.valid_o !== 1'b1) begin bad++; $display("FAIL midreset_capture: got %b expected 1", pif.valid_o); end
        total++; if (pif.period_o !== CNT_W'(20)) begin bad++; $display("FAIL midreset_period: got %0d expected 20", pif.period_o); end
    endtask

    initial begin
        pif.ack_i = 1'b0;
        test_reset();
        test_no_ack();
        test_ack_pulsed();
        test_ack_coincident();
        test_timeout();
        test_reset_mid();
        repeat (3) tick();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of a slow, asynchronous square wave (divided clock, wheel-encoder or bump-sensor line on the TekBot) in units of the fast system clock. It is the receiving end of the clock-divider path: where the divider turns a count into a slow clock, this block turns a slow clock back into a count. Results go to the TekBot state machine through a valid/ack handshake.

## Interface
- `CNT_W`, default 21: width of the period counter and result.
- `TIMEOUT`, default 2_000_000: number of cycles without a rising edge before a timeout is declared. Must be ≤ 2^CNT_W − 1.
- `clk_i`, input, 1: system clock. All logic is on the rising edge.
- `reset_n`, input, 1: reset, asynchronous and active-low. The block has one clock.
- `sig_i`, input, 1: measured signal, asynchronous to `clk_i`.
- `ack_i`, input, 1: consumer acknowledge. Sampled only while `valid_o` = 1.
- `period_o`, output, CNT_W: last captured period in `clk_i` cycles.
- `valid_o`, output, 1: `period_o` holds an unacknowledged result.
- `edge_o`, output, 1: one-cycle pulse per detected rising edge of `sig_i`.
- `overrun_o`, output, 1: sticky flag. A result was overwritten before it was acknowledged.
- `timeout_o`, output, 1: sticky flag. No edge occurred within `TIMEOUT` cycles.

## Operation
- Input path:
  - Two-flop synchronizer (`s1`, `s2`), then a third flop `s3`.
  - `edge_o` = `s2 & ~s3`.
- FSM states are IDLE and RUN. The block resets to IDLE.
- IDLE:
  - The counter is held at 0.
  - On `edge_o`: go to RUN with count = 0. No capture.
- RUN:
  - The counter increments every cycle.
  - On `edge_o`: `period_o` ← count + 1, count ← 0, `valid_o` ← 1, `timeout_o` ← 0. Stay in RUN.
  - When count = TIMEOUT − 1 with no edge that cycle: `timeout_o` ← 1, go to IDLE. `period_o` and `valid_o` are unchanged.
  - An edge in the same cycle as the timeout condition counts as an edge. The edge wins.
- Handshake:
  - A capture sets `valid_o`.
  - `ack_i` with `valid_o` = 1 and no capture that cycle clears `valid_o`.
  - A capture and `ack_i` in the same cycle: `valid_o` stays 1 with the new data, and no overrun is flagged.
- Overrun:
  - A capture while `valid_o` = 1 and `ack_i` = 0 sets `overrun_o`. New data replaces old.
  - `ack_i` (with `valid_o` = 1) clears `overrun_o`, unless an overrun is set in the same cycle. Set has priority.
- Arithmetic:
  - count + 1 is computed CNT_W wide.
  - The timeout guarantees count never wraps.

## Timing
- Reset values: `period_o` = 0, `valid_o` = 0, `edge_o` = 0, `overrun_o` = 0, `timeout_o` = 0. `s1`/`s2`/`s3` = 0, count = 0, state = IDLE.
- Reset is asynchronous. Asserting it mid-measurement aborts the measurement immediately, and nothing is captured.
- Edge latency: a `sig_i` rise before clock edge k makes `edge_o` = 1 in the cycle after edge k+1 (2 cycles latency).
- If `sig_i` is already high at reset release, the synchronizer sees a rise, and this counts as the first edge (IDLE→RUN).
- Capture latency: `period_o`/`valid_o` update on the clock edge that ends the `edge_o` cycle. That is 3 cycles after the input rise.
- A stable square wave of period P ≥ 2 cycles gives `period_o` = P from the second edge on.
- Minimum measurable period is 2 cycles. Maximum is TIMEOUT.

## Structure
- Package `period_meter_pkg` holds:
  - the `pm_state_t` enum (IDLE, RUN);
  - default `CNT_W` and `TIMEOUT` constants.
- Sub-module `sync_edge_detect` contains:
  - the synchronizer, `s3`, and `edge_o` generation;
  - ports `clk_i`, `reset_n`, `async_i`, `rise_o`.
- Top level holds the FSM, counter, capture register and handshake/flag logic.

## Test plan
- Square wave, 10 cycles high / 10 low, no `ack_i` → first capture `period_o` = 20 and `valid_o` = 1; the second capture sets `overrun_o` = 1; `period_o` stays 20.
- Same wave with `ack_i` pulsed 1 cycle after each `valid_o` → `period_o` = 20 every time; `valid_o` drops one cycle after `ack_i`; `overrun_o` stays 0.
- `ack_i` coincident with a capture → `valid_o` stays 1, `period_o` = new value, `overrun_o` = 0.
- TIMEOUT = 100, one edge then `sig_i` held low → `timeout_o` = 1 exactly 100 cycles after `edge_o`, state IDLE; next two edges 30 cycles apart → `period_o` = 30, `timeout_o` = 0.
- `reset_n` low mid-period, with `sig_i` high at release → all outputs 0; IDLE→RUN on the synthetic edge; no capture until the next genuine rise.
